// File: rtl/lsq_mem_sched_pkg.sv
// Shared size codes, scheduler state encoding and default widths for the load/store queue.
// Combinational declarations only; no latency or backpressure of its own.
package lsq_mem_sched_pkg;

  localparam int TAG_W_DEF = 3;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/lsq_mem_sched_fifo.sv
// In-order entry storage with wrap-bit pointers and an oldest-first tag CAM for address resolve.
// Enqueue/resolve/dequeue take effect at the next edge; enq_ready is !full and is not freed by a same-cycle dequeue.
module lsq_fifo
  import lsq_mem_sched_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = TAG_W_DEF,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     enq_valid,
  input  logic [TAG_W-1:0]         enq_tag,
  input  logic                     enq_store,
  input  logic [2:0]               enq_size,
  output logic                     enq_ready,
  input  logic                     addr_valid,
  input  logic [TAG_W-1:0]         addr_tag,
  input  logic [XLEN-1:0]          addr,
  input  logic [XLEN-1:0]          sdata,
  input  logic                     deq,
  output logic                     head_valid,
  output logic                     head_addr_ok,
  output logic                     head_store,
  output logic [2:0]               head_size,
  output logic [TAG_W-1:0]         head_tag,
  output logic [XLEN-1:0]          head_addr,
  output logic [XLEN-1:0]          head_sdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic             r_valid   [DEPTH];
  logic             r_addr_ok [DEPTH];
  logic [TAG_W-1:0] r_tag     [DEPTH];
  logic             r_store   [DEPTH];
  logic [2:0]       r_size    [DEPTH];
  logic [XLEN-1:0]  r_addr    [DEPTH];
  logic [XLEN-1:0]  r_sdata   [DEPTH];

  logic          w_full;
  logic          w_enq;
  logic          w_hit;
  logic [IW-1:0] w_hit_idx;
  logic [IW-1:0] w_scan_idx;
  logic          w_res_fire;
  logic [IW-1:0] w_head_idx;
  logic [IW-1:0] w_tail_idx;

  assign w_head_idx = r_head[IW-1:0];
  assign w_tail_idx = r_tail[IW-1:0];
  assign w_full     = (w_head_idx == w_tail_idx) && (r_head[IW] != r_tail[IW]);
  assign enq_ready  = !w_full;
  assign count      = r_tail - r_head;

  // Tag 0 means "no producer" and is never allowed into the queue.
  assign w_enq = enq_valid && !w_full && (enq_tag != '0);

  // Scan from head so the first hit is the oldest unresolved entry with this tag.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_scan_idx = w_head_idx + IW'(i);
      if (!w_hit && r_valid[w_scan_idx] && !r_addr_ok[w_scan_idx] &&
          (r_tag[w_scan_idx] == addr_tag)) begin
        w_hit     = 1'b1;
        w_hit_idx = w_scan_idx;
      end
    end
  end

  assign w_res_fire = addr_valid && w_hit && !(w_enq && (enq_tag == addr_tag));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i]   <= 1'b0;
        r_addr_ok[i] <= 1'b0;
      end
    end else if (flush) begin
      r_tail <= r_head;
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i]   <= 1'b0;
        r_addr_ok[i] <= 1'b0;
      end
    end else begin
      if (w_enq) begin
        r_valid[w_tail_idx]   <= 1'b1;
        r_addr_ok[w_tail_idx] <= 1'b0;
        r_tail                <= r_tail + PW'(1);
      end
      if (w_res_fire) begin
        r_addr_ok[w_hit_idx] <= 1'b1;
      end
      if (deq) begin
        r_valid[w_head_idx]   <= 1'b0;
        r_addr_ok[w_head_idx] <= 1'b0;
        r_head                <= r_head + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && w_enq) begin
      r_tag[w_tail_idx]   <= enq_tag;
      r_store[w_tail_idx] <= enq_store;
      r_size[w_tail_idx]  <= enq_size;
    end
    if (!flush && w_res_fire) begin
      r_addr[w_hit_idx]  <= addr;
      r_sdata[w_hit_idx] <= sdata;
    end
  end

  assign head_valid   = r_valid[w_head_idx];
  assign head_addr_ok = r_addr_ok[w_head_idx];
  assign head_store   = r_store[w_head_idx];
  assign head_size    = r_size[w_head_idx];
  assign head_tag     = r_tag[w_head_idx];
  assign head_addr    = r_addr[w_head_idx];
  assign head_sdata   = r_sdata[w_head_idx];

endmodule

// File: rtl/lsq_mem_sched.sv
// Issues queued loads/stores to the single RAM port strictly in program order, one at a time.
// Issue 1 cycle after head is resolved and RAM idle; result held on res_* until res_grant.
module lsq_mem_sched
  import lsq_mem_sched_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = TAG_W_DEF,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enq_valid,
  input  logic [TAG_W-1:0]       enq_tag,
  input  logic                   enq_store,
  input  logic [2:0]             enq_size,
  output logic                   enq_ready,
  input  logic                   addr_valid,
  input  logic [TAG_W-1:0]       addr_tag,
  input  logic [XLEN-1:0]        addr,
  input  logic [XLEN-1:0]        sdata,
  input  logic                   flush,
  output logic                   mem_start,
  output logic                   mem_we,
  output logic [XLEN-1:0]        mem_addr,
  output logic [XLEN-1:0]        mem_wdata,
  output logic [2:0]             mem_size,
  input  logic                   mem_busy,
  input  logic                   mem_done,
  input  logic [XLEN-1:0]        mem_rdata,
  output logic                   res_valid,
  output logic [TAG_W-1:0]       res_tag,
  output logic [XLEN-1:0]        res_data,
  input  logic                   res_grant,
  output logic [$clog2(DEPTH):0] count
);

  state_t           r_state;
  logic             r_mem_start;
  logic             r_mem_we;
  logic [XLEN-1:0]  r_mem_addr;
  logic [XLEN-1:0]  r_mem_wdata;
  logic [2:0]       r_mem_size;
  logic [TAG_W-1:0] r_tag;
  logic             r_drop;
  logic             r_res_valid;
  logic [TAG_W-1:0] r_res_tag;
  logic [XLEN-1:0]  r_res_data;

  logic             w_deq;
  logic             w_head_vld;
  logic             w_head_ok;
  logic             w_head_store;
  logic [2:0]       w_head_size;
  logic [TAG_W-1:0] w_head_tag;
  logic [XLEN-1:0]  w_head_addr;
  logic [XLEN-1:0]  w_head_sdata;
  logic [XLEN-1:0]  w_ext;

  assign w_deq = (r_state == ST_RESP) && res_grant && !flush;

  lsq_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W),
    .XLEN  (XLEN)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .enq_valid    (enq_valid),
    .enq_tag      (enq_tag),
    .enq_store    (enq_store),
    .enq_size     (enq_size),
    .enq_ready    (enq_ready),
    .addr_valid   (addr_valid),
    .addr_tag     (addr_tag),
    .addr         (addr),
    .sdata        (sdata),
    .deq          (w_deq),
    .head_valid   (w_head_vld),
    .head_addr_ok (w_head_ok),
    .head_store   (w_head_store),
    .head_size    (w_head_size),
    .head_tag     (w_head_tag),
    .head_addr    (w_head_addr),
    .head_sdata   (w_head_sdata),
    .count        (count)
  );

  always_comb begin
    case (r_mem_size)
      MEM_B:   w_ext = {{(XLEN-8){mem_rdata[7]}}, mem_rdata[7:0]};
      MEM_H:   w_ext = {{(XLEN-16){mem_rdata[15]}}, mem_rdata[15:0]};
      MEM_BU:  w_ext = {{(XLEN-8){1'b0}}, mem_rdata[7:0]};
      MEM_HU:  w_ext = {{(XLEN-16){1'b0}}, mem_rdata[15:0]};
      default: w_ext = mem_rdata;
    endcase
  end

  // A flushed op that already reached the RAM must still see its mem_done; r_drop swallows it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mem_start <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_size  <= '0;
      r_tag       <= '0;
      r_drop      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_tag   <= '0;
      r_res_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!flush && w_head_vld && w_head_ok && !mem_busy) begin
            r_mem_start <= 1'b1;
            r_mem_we    <= w_head_store;
            r_mem_addr  <= w_head_addr;
            r_mem_wdata <= w_head_sdata;
            r_mem_size  <= w_head_size;
            r_tag       <= w_head_tag;
            r_drop      <= 1'b0;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_mem_start <= 1'b0;
          r_state     <= ST_WAIT;
          if (flush) r_drop <= 1'b1;
        end
        ST_WAIT: begin
          if (mem_done) begin
            if (r_drop || flush) begin
              r_drop  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_res_valid <= 1'b1;
              r_res_tag   <= r_tag;
              r_res_data  <= r_mem_we ? '0 : w_ext;
              r_state     <= ST_RESP;
            end
          end else if (flush) begin
            r_drop <= 1'b1;
          end
        end
        ST_RESP: begin
          if (flush || res_grant) begin
            r_res_valid <= 1'b0;
            r_res_tag   <= '0;
            r_res_data  <= '0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_start = r_mem_start;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_size  = r_mem_size;
  assign res_valid = r_res_valid;
  assign res_tag   = r_res_tag;
  assign res_data  = r_res_data;

endmodule

// File: tb/tb_lsq_mem_sched.sv
// Directed bench for lsq_mem_sched: ordering, extension, full queue, flush and reset cases.
module tb_lsq_mem_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enq_valid = 1'b0;
  logic [2:0]  enq_tag = '0;
  logic        enq_store = 1'b0;
  logic [2:0]  enq_size = '0;
  logic        enq_ready;
  logic        addr_valid = 1'b0;
  logic [2:0]  addr_tag = '0;
  logic [31:0] addr = '0;
  logic [31:0] sdata = '0;
  logic        flush = 1'b0;
  logic        mem_start;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_size;
  logic        mem_busy = 1'b0;
  logic        mem_done = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        res_valid;
  logic [2:0]  res_tag;
  logic [31:0] res_data;
  logic        res_grant = 1'b0;
  logic [3:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  lsq_mem_sched #(.DEPTH(8), .TAG_W(3), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_tag(enq_tag), .enq_store(enq_store), .enq_size(enq_size),
    .enq_ready(enq_ready),
    .addr_valid(addr_valid), .addr_tag(addr_tag), .addr(addr), .sdata(sdata),
    .flush(flush),
    .mem_start(mem_start), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_busy(mem_busy), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data), .res_grant(res_grant),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_enq(input logic [2:0] tag, input logic st, input logic [2:0] sz);
    enq_valid = 1'b1; enq_tag = tag; enq_store = st; enq_size = sz;
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic do_res(input logic [2:0] tag, input logic [31:0] a, input logic [31:0] d);
    addr_valid = 1'b1; addr_tag = tag; addr = a; sdata = d;
    tick();
    addr_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!mem_start && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, mem_start}, 32'd1);
  endtask

  task automatic pulse_done(input logic [31:0] d);
    mem_done = 1'b1; mem_rdata = d;
    tick();
    mem_done = 1'b0;
  endtask

  task automatic run_load(input logic [2:0] tag, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] rd, input logic [31:0] exp);
    do_enq(tag, 1'b0, sz);
    do_res(tag, a, 32'h0);
    wait_start("ld_start");
    chk("ld_addr", mem_addr, a);
    chk("ld_size", {29'd0, mem_size}, {29'd0, sz});
    tick();
    pulse_done(rd);
    chk("ld_res_tag", {29'd0, res_tag}, {29'd0, tag});
    chk("ld_res_data", res_data, exp);
    res_grant = 1'b1;
    tick();
    res_grant = 1'b0;
    chk("ld_res_clear", {31'd0, res_valid}, 32'd0);
  endtask

  logic [2:0]  ext_sz [4] = '{3'b001, 3'b100, 3'b101, 3'b011};
  logic [31:0] ext_ex [4] = '{32'hFFFF8081, 32'h00000081, 32'h00008081, 32'hCAFE8081};

  initial begin
    int seen;
    @(negedge clk);
    tick();
    rst = 1'b0;
    chk("rst_enq_ready", {31'd0, enq_ready}, 32'd1);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_mem_start", {31'd0, mem_start}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);

    // Signed byte load; RAM busy holds off issue.
    do_enq(3'd2, 1'b0, 3'b000);
    chk("t1_count", {28'd0, count}, 32'd1);
    mem_busy = 1'b1;
    do_res(3'd2, 32'h10, 32'h0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      seen |= int'(mem_start);
      tick();
    end
    chk("t1_busy_hold", seen, 32'd0);
    mem_busy = 1'b0;
    wait_start("t1_start");
    chk("t1_we", {31'd0, mem_we}, 32'd0);
    chk("t1_addr", mem_addr, 32'h10);
    tick();
    chk("t1_start_one_cycle", {31'd0, mem_start}, 32'd0);
    pulse_done(32'h000000F0);
    for (int i = 0; i < 5; i++) begin
      chk("t1_hold_valid", {31'd0, res_valid}, 32'd1);
      chk("t1_hold_tag", {29'd0, res_tag}, 32'd2);
      chk("t1_hold_data", res_data, 32'hFFFFFFF0);
      chk("t1_hold_no_start", {31'd0, mem_start}, 32'd0);
      tick();
    end
    res_grant = 1'b1;
    tick();
    res_grant = 1'b0;
    chk("t1_res_clear", {31'd0, res_valid}, 32'd0);
    chk("t1_count_after", {28'd0, count}, 32'd0);

    // Store before load; younger resolved load must wait for older store.
    do_enq(3'd1, 1'b1, 3'b010);
    do_enq(3'd3, 1'b0, 3'b010);
    do_res(3'd3, 32'h30, 32'h0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      seen |= int'(mem_start);
      tick();
    end
    chk("t2_no_issue_unresolved_head", seen, 32'd0);
    do_res(3'd1, 32'h20, 32'hDEADBEEF);
    wait_start("t2_st_start");
    chk("t2_st_we", {31'd0, mem_we}, 32'd1);
    chk("t2_st_addr", mem_addr, 32'h20);
    chk("t2_st_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    pulse_done(32'h12345678);
    chk("t2_st_tag", {29'd0, res_tag}, 32'd1);
    chk("t2_st_data", res_data, 32'd0);
    tick();
    chk("t2_no_start_in_resp", {31'd0, mem_start}, 32'd0);
    res_grant = 1'b1;
    tick();
    res_grant = 1'b0;
    chk("t2_gap_idle", {31'd0, mem_start}, 32'd0);
    chk("t2_count", {28'd0, count}, 32'd1);
    tick();
    chk("t2_ld_start", {31'd0, mem_start}, 32'd1);
    chk("t2_ld_we", {31'd0, mem_we}, 32'd0);
    chk("t2_ld_addr", mem_addr, 32'h30);
    tick();
    pulse_done(32'hCAFE8001);
    chk("t2_ld_tag", {29'd0, res_tag}, 32'd3);
    chk("t2_ld_data", res_data, 32'hCAFE8001);
    res_grant = 1'b1;
    tick();
    res_grant = 1'b0;

    // Extension table: H, BU, HU and an undefined code treated as W.
    for (int i = 0; i < 4; i++)
      run_load(3'(i + 4), ext_sz[i], 32'h100 + 32'(i * 4), 32'hCAFE8081, ext_ex[i]);

    // Fill the queue, drop a 9th enqueue, free one slot and wrap.
    for (int i = 0; i < 8; i++) do_enq(3'((i % 7) + 1), 1'b0, 3'b010);
    chk("t3_full_count", {28'd0, count}, 32'd8);
    chk("t3_full_ready", {31'd0, enq_ready}, 32'd0);
    do_enq(3'd5, 1'b0, 3'b010);
    chk("t3_drop_count", {28'd0, count}, 32'd8);
    do_res(3'd1, 32'h40, 32'h0);
    wait_start("t3_start");
    chk("t3_oldest_tag1", mem_addr, 32'h40);
    tick();
    pulse_done(32'h11);
    chk("t3_res_tag", {29'd0, res_tag}, 32'd1);
    res_grant = 1'b1;
    tick();
    res_grant = 1'b0;
    chk("t3_after_grant_count", {28'd0, count}, 32'd7);
    chk("t3_after_grant_ready", {31'd0, enq_ready}, 32'd1);
    do_enq(3'd6, 1'b0, 3'b010);
    chk("t3_wrap_count", {28'd0, count}, 32'd8);
    chk("t3_wrap_ready", {31'd0, enq_ready}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t3_flush_count", {28'd0, count}, 32'd0);
    chk("t3_flush_ready", {31'd0, enq_ready}, 32'd1);

    // Flush while waiting on RAM: the late completion is swallowed.
    do_enq(3'd1, 1'b0, 3'b010);
    do_enq(3'd2, 1'b0, 3'b010);
    do_enq(3'd3, 1'b0, 3'b010);
    do_res(3'd1, 32'h50, 32'h0);
    wait_start("t4_start");
    tick();
    chk("t4_count_wait", {28'd0, count}, 32'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_flush_count", {28'd0, count}, 32'd0);
    pulse_done(32'h55);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      seen |= int'(res_valid) | int'(mem_start);
      tick();
    end
    chk("t4_no_resp", seen, 32'd0);
    run_load(3'd4, 3'b000, 32'h54, 32'h00000080, 32'hFFFFFF80);

    // Flush during RESP drops the held result.
    do_enq(3'd2, 1'b1, 3'b010);
    do_res(3'd2, 32'h60, 32'h1);
    wait_start("t5_start");
    tick();
    pulse_done(32'h0);
    chk("t5_resp_valid", {31'd0, res_valid}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_flush_res_valid", {31'd0, res_valid}, 32'd0);
    chk("t5_flush_count", {28'd0, count}, 32'd0);

    // Synchronous reset in WAIT, then a late completion.
    do_enq(3'd5, 1'b0, 3'b010);
    do_res(3'd5, 32'h70, 32'h0);
    wait_start("t6_start");
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_outs", {mem_start, mem_we, res_valid, res_tag, mem_size}, 32'd0);
    chk("t6_rst_addr", mem_addr | mem_wdata | res_data, 32'd0);
    chk("t6_rst_count", {28'd0, count}, 32'd0);
    chk("t6_rst_ready", {31'd0, enq_ready}, 32'd1);
    pulse_done(32'h77);
    chk("t6_late_done", {31'd0, res_valid}, 32'd0);
    tick();
    chk("t6_late_done2", {30'd0, res_valid, mem_start}, 32'd0);
    run_load(3'd6, 3'b000, 32'h74, 32'h0000007F, 32'h0000007F);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
